// File: rtl/param_word_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : param_word_fifo_if
// Purpose  : Valid/ready bundle for param_word_fifo. Carries the upstream
//            (in_*) and downstream (out_*) handshakes plus the full/empty
//            status flags.
// Modports : master - the side that supplies words and consumes the head
//            slave  - the FIFO itself
// Revision : 1.0 - initial release
// ============================================================================
interface param_word_fifo_if #(
  parameter int unsigned word_size = 32,
  parameter type         T         = logic [word_size-1:0]
);

  logic in_valid;
  logic in_ready;
  T     in_data;
  logic out_valid;
  logic out_ready;
  T     out_data;
  logic full;
  logic empty;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, full, empty
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, full, empty
  );

endinterface
`default_nettype wire

// File: rtl/param_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_word_fifo
// Purpose  : Synchronous word FIFO feeding the parameterised memory write
//            port. Geometry follows the memory's dependent parameters:
//            depth = memory_size / word_size / 1024.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous active-high reset
//            bus   - param_word_fifo_if.slave (in_valid/in_ready/in_data,
//                    out_valid/out_ready/out_data, full, empty)
//            count - occupancy 0..depth (only with PARAM_WORD_FIFO_COUNT_EN)
// Options  : `define PARAM_WORD_FIFO_COUNT_EN adds the count port and an
//            occupancy-range assertion.
// Revision : 1.0 - initial release
// ============================================================================
module param_word_fifo #(
  parameter int unsigned word_size   = 32,
  parameter int unsigned memory_size = word_size * 4096,
  parameter int unsigned depth       = memory_size / word_size / 1024,
  parameter type         T           = logic [word_size-1:0]
) (
  input  wire logic        clk,
  input  wire logic        rst,
  param_word_fifo_if.slave bus
`ifdef PARAM_WORD_FIFO_COUNT_EN
  ,
  output logic [$clog2(depth):0] count
`endif
);

  localparam int unsigned addr_w = $clog2(depth);

  localparam logic [addr_w:0] c_ptr_one  = (addr_w+1)'(1);
  localparam logic [addr_w:0] c_occ_last = (addr_w+1)'(depth - 1);

  // Elaboration-time geometry checks.
  if (word_size < 1) begin : g_chk_word_size
    $error("param_word_fifo: word_size must be at least 1");
  end
  if ($bits(T) != word_size) begin : g_chk_type
    $error("param_word_fifo: $bits(T) must equal word_size");
  end
  if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_chk_depth
    $error("param_word_fifo: depth must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  T                mem_q [depth];
  logic [addr_w:0] wp_q, wp_d;
  logic [addr_w:0] rp_q, rp_d;
  state_t          state_q, state_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [addr_w:0] occ;

  // The extra pointer MSB separates "same slot, one lap apart" (full)
  // from "same slot, same lap" (empty).
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[addr_w-1:0] == rp_q[addr_w-1:0]) &&
                 (wp_q[addr_w] != rp_q[addr_w]);
  assign occ   = wp_q - rp_q;

  // Ready/valid depend on stored state only, never on the opposite
  // handshake input, so there is no combinational in->out path.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.out_data  = mem_q[rp_q[addr_w-1:0]];

  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  assign wp_d = push ? (wp_q + c_ptr_one) : wp_q;
  assign rp_d = pop  ? (rp_q + c_ptr_one) : rp_q;

  // Occupancy class; simultaneous push and pop keep the class unchanged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (push && !pop) state_d = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (push && !pop && (occ == c_occ_last)) state_d = S_FULL;
        else if (pop && !push && (occ == c_ptr_one)) state_d = S_EMPTY;
      end
      S_FULL: begin
        if (pop) state_d = S_PARTIAL;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      state_q <= S_EMPTY;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      state_q <= state_d;
    end
  end

  // Storage is deliberately not reset; a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wp_q[addr_w-1:0]] <= bus.in_data;
    end
  end

  // The occupancy class must agree with the pointer-derived flags.
  a_state_flags: assert property (@(posedge clk) disable iff (rst)
    ((state_q == S_EMPTY) == empty) && ((state_q == S_FULL) == full));

`ifdef PARAM_WORD_FIFO_COUNT_EN
  assign count = occ;

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    (32'(count) <= depth));
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_word_fifo
// Purpose  : Self-checking bench for param_word_fifo. Two instances: the
//            default geometry (32-bit, 4 entries) and an override
//            (8-bit, memory_size 65536 -> 8 entries). A queue per instance
//            holds the words expected at the output; monitors pop and
//            compare whenever a transfer happens at the output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_word_fifo;

  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_word_fifo_if #(.word_size(32)) ifa ();
  param_word_fifo_if #(.word_size(8))  ifb ();

`ifdef PARAM_WORD_FIFO_COUNT_EN
  logic [2:0] count_a;
  logic [3:0] count_b;
`endif

  param_word_fifo dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
`ifdef PARAM_WORD_FIFO_COUNT_EN
    ,
    .count (count_a)
`endif
  );

  param_word_fifo #(.word_size(8), .memory_size(65536)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
`ifdef PARAM_WORD_FIFO_COUNT_EN
    ,
    .count (count_b)
`endif
  );

  logic [31:0] qa [$];
  logic [7:0]  qb [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Status flags must match the reference occupancy (entries in the queue).
  task automatic chk_flags_a();
    int n = qa.size();
    chk("a_empty",     32'(ifa.empty),     32'(n == 0));
    chk("a_full",      32'(ifa.full),      32'(n == DEPTH_A));
    chk("a_in_ready",  32'(ifa.in_ready),  32'(n != DEPTH_A));
    chk("a_out_valid", 32'(ifa.out_valid), 32'(n != 0));
`ifdef PARAM_WORD_FIFO_COUNT_EN
    chk("a_count", 32'(count_a), 32'(n));
`endif
  endtask

  task automatic chk_flags_b();
    int n = qb.size();
    chk("b_empty",     32'(ifb.empty),     32'(n == 0));
    chk("b_full",      32'(ifb.full),      32'(n == DEPTH_B));
    chk("b_in_ready",  32'(ifb.in_ready),  32'(n != DEPTH_B));
    chk("b_out_valid", 32'(ifb.out_valid), 32'(n != 0));
`ifdef PARAM_WORD_FIFO_COUNT_EN
    chk("b_count", 32'(count_b), 32'(n));
`endif
  endtask

  // One cycle on instance A: check state, drive inputs on the falling edge,
  // and record the word that the coming rising edge will accept.
  task automatic step_a(input bit iv, input logic [31:0] d, input bit ordy, input bit r);
    @(negedge clk);
    chk_flags_a();
    ifa.in_valid  = iv;
    ifa.in_data   = d;
    ifa.out_ready = ordy;
    rst           = r;
    if (r) begin
      qa.delete();
      qb.delete();
    end else if (iv && (qa.size() < DEPTH_A)) begin
      qa.push_back(d);
    end
  endtask

  task automatic step_b(input bit iv, input logic [7:0] d, input bit ordy, input bit r);
    @(negedge clk);
    chk_flags_b();
    ifb.in_valid  = iv;
    ifb.in_data   = d;
    ifb.out_ready = ordy;
    rst           = r;
    if (r) begin
      qa.delete();
      qb.delete();
    end else if (iv && (qb.size() < DEPTH_B)) begin
      qb.push_back(d);
    end
  endtask

  // Output monitors: sample mid-cycle, after the inputs have settled.
  always @(negedge clk) begin
    #2;
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) chk("a_pop_unexpected", 32'(1), 32'(0));
      else chk("a_out_data", ifa.out_data, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) chk("b_pop_unexpected", 32'(1), 32'(0));
      else chk("b_out_data", 32'(ifb.out_data), 32'(qb.pop_front()));
    end
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Release reset, then idle for three checked cycles.
    step_a(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step_a(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to full, refuse a fifth word, drain in order.
    for (int i = 0; i < 4; i++) step_a(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step_a(1'b1, 32'hA4, 1'b0, 1'b0);
    chk("a_fifth_refused", 32'(ifa.in_ready), 32'(0));
    for (int i = 0; i < 4; i++) step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b0, 1'b0);

    // Wrap-around with a one-word offset: 1..10.
    step_a(1'b1, 32'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 10; i++) step_a(1'b1, 32'(i), 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b0, 1'b0);

    // Full with push and pop together: only the pop happens.
    for (int i = 0; i < 4; i++) step_a(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    step_a(1'b1, 32'hEE, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b0, 1'b0);
    chk("a_occ3_in_ready", 32'(ifa.in_ready), 32'(1));
    for (int i = 0; i < 3; i++) step_a(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset mid-operation, with a push on the reset edge.
    step_a(1'b1, 32'h11, 1'b0, 1'b0);
    step_a(1'b1, 32'h22, 1'b0, 1'b0);
    step_a(1'b1, 32'h77, 1'b1, 1'b1);
    step_a(1'b1, 32'h55, 1'b0, 1'b0);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b0, 1'b0);

    // Randomised traffic on A, with occasional resets.
    for (int i = 0; i < 300; i++)
      step_a(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 63) == 0));
    for (int i = 0; i < DEPTH_A + 2; i++) step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b0, 1'b0);

    // Override geometry: 8 entries of 8 bits.
    step_b(1'b0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step_b(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step_b(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("b_full_after_8", 32'(ifb.full), 32'(1));
    for (int i = 0; i < 8; i++) step_b(1'b0, 8'h0, 1'b1, 1'b0);
    step_b(1'b1, 8'hFF, 1'b0, 1'b0);
    step_b(1'b0, 8'h0, 1'b1, 1'b0);
    step_b(1'b0, 8'h0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      step_b(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 63) == 0));
    for (int i = 0; i < DEPTH_B + 2; i++) step_b(1'b0, 8'h0, 1'b1, 1'b0);
    step_b(1'b0, 8'h0, 1'b0, 1'b0);
    step_a(1'b0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_word_fifo.md
Name: param_word_fifo

Overview:
- Synchronous word buffer placed directly upstream of the parameterised memory block. Its geometry uses the same dependent-parameter scheme as that memory: `word_size`, and `memory_size` defaulting to `word_size * 4096`.
- Accepts words on a valid/ready input, stores them, and presents them in order on a valid/ready output to the memory write port.
- Also exercises parameter dependence in elaboration tests: port widths, entry count and the type of a derived parameter all follow from overridable parameters.

Parameters:
- `word_size`, 32: data width in bits; must be at least 1.
- `memory_size`, `word_size * 4096`: total downstream memory size in bits; used only to derive `depth`.
- `depth`, `memory_size / word_size / 1024` (4 by default): number of FIFO entries; must be a power of two, at least 2.
- `addr_w`, `$clog2(depth)`: pointer width; derived, never overridden.
- `type T`, `logic [word_size-1:0]`: element type of stored words; `$bits(T)` must equal `word_size`.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream word available.
- `in_ready`, output, 1: FIFO can accept a word.
- `in_data`, input, `word_size`: upstream word (type T).
- `out_valid`, output, 1: head word available.
- `out_ready`, input, 1: downstream accepts the head word.
- `out_data`, output, `word_size`: head word (type T).
- `full`, output, 1: occupancy equals `depth`.
- `empty`, output, 1: occupancy is 0.

Behaviour:
- Storage: `depth` entries of T. Write pointer `wp` and read pointer `rp` are `addr_w+1` bits wide; the MSB is the wrap bit.
- Status:
  - empty = (`wp` == `rp`).
  - full = (`wp[addr_w-1:0]` == `rp[addr_w-1:0]`) && (`wp[addr_w]` != `rp[addr_w]`).
- Handshake:
  - push = `in_valid` && `in_ready`; pop = `out_valid` && `out_ready`.
  - `in_ready` = !full; `out_valid` = !empty. Both are combinational from state only, never from the opposite handshake input.
- Data path:
  - `out_data` = mem[`rp[addr_w-1:0]`], read combinationally.
  - Latency: a word pushed in cycle N is visible on `out_data` with `out_valid`=1 in cycle N+1 (no fall-through).
- Push: mem[`wp`] <= `in_data`, then `wp` <= `wp`+1, wrapping modulo 2^(`addr_w`+1).
- Pop: `rp` <= `rp`+1, same wrap rule.
- Simultaneous push and pop:
  - Allowed whenever not full and not empty; occupancy is unchanged and both pointers advance.
  - When full, push is blocked by `in_ready`=0 and pop proceeds.
  - When empty, pop is blocked by `out_valid`=0 and push proceeds.
- Occupancy state machine:
  - EMPTY → PARTIAL on push-only.
  - PARTIAL → FULL when a push-only reaches occupancy `depth`.
  - PARTIAL → EMPTY when a pop-only reaches occupancy 0.
  - FULL → PARTIAL on pop.
  - Push and pop together leave the state unchanged.
- Reset, applied at any clock edge including mid-transfer:
  - `wp`=0 and `rp`=0; empty=1, full=0, `in_ready`=1, `out_valid`=0.
  - Storage contents are not reset; `out_data` is don't-care while `out_valid`=0.
  - A push or pop presented in the reset cycle is discarded.
- Width and type:
  - `in_data` and `out_data` are exactly `word_size` bits; no truncation or extension inside the block.
  - With T overridden, stored values keep T's bit pattern.

Optional Feature:
- Macro: `PARAM_WORD_FIFO_COUNT_EN`.
- Defined:
  - Adds output port `count`, width `addr_w+1`, equal to `wp` - `rp` modulo 2^(`addr_w`+1), giving occupancy 0..`depth`.
  - `count` updates in the same cycle as `full` and `empty`, and resets to 0.
  - Also adds an assertion that `count` <= `depth`.
- Undefined: no `count` port and no assertion; all other behaviour is identical.

Test Plan:
- Reset, then idle for 3 cycles → `empty`=1, `full`=0, `in_ready`=1, `out_valid`=0 throughout.
- Defaults (`word_size`=32, `depth`=4): push 0xA0..0xA3 on 4 consecutive cycles → `full`=1 after the 4th push. A 5th push of 0xA4 is refused (`in_ready`=0). Popping 4 words yields 0xA0, 0xA1, 0xA2, 0xA3, then `empty`=1.
- Wrap-around: perform 10 push/pop pairs with a one-word offset, data 1..10 → output order is 1..10, pointers wrap past 7 with no loss, and `count` (if enabled) stays 1.
- Full plus simultaneous pop: at `full`=1, drive `in_valid`=1 and `out_ready`=1 → only the pop occurs; the next cycle has occupancy 3 and `in_ready`=1.
- Reset mid-operation: push 2 words, then assert `rst` on the same edge as a push → afterwards `empty`=1, `out_valid`=0, and the next push of 0x55 is the first word out.
- Override `#(.word_size(8), .memory_size(65536))` → `depth`=8 and `addr_w`=3. Port width is 8. 8 pushes reach full; pushing 0xFF returns 0xFF.
